// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// Module      : seq_detector_param
// Description : Serial pattern detector with a runtime-programmable pattern,
//               overlap mode and a saturating match counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1001),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           Sin,
    input  logic                           en,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           out,
    output logic [CNT_W-1:0]               match_count,
    output logic [$clog2(MAX_LEN+1)-1:0]   cur_len
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_rst_len = (RST_LEN > MAX_LEN) ? c_max_len
                                                                 : LEN_W'(RST_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Configuration
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;

    // Datapath state
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_out;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_cfg_len;
    logic               w_match;
    logic               w_hit;

    // Only the low len bits of history take part in the comparison.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = (r_len > LEN_W'(gi));
    end

    assign w_hist_n  = {r_hist[MAX_LEN-2:0], Sin};
    assign w_fill_n  = (r_fill < r_len) ? (r_fill + 1'b1) : r_len;
    assign w_cfg_len = (cfg_len > c_max_len) ? c_max_len : cfg_len;

    // len=0 would otherwise trivially satisfy both terms, so it is excluded.
    assign w_match = (r_len != '0)
                   && (w_fill_n == r_len)
                   && (((w_hist_n ^ r_pat) & w_mask) == '0);

    assign w_hit = en && !cfg_load && w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat  <= RST_PATTERN;
            r_len  <= c_rst_len;
            r_ovl  <= RST_OVERLAP;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (cfg_load) begin
            r_pat  <= cfg_pattern;
            r_len  <= w_cfg_len;
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            r_fill <= (w_match && !r_ovl) ? '0 : w_fill_n;
            r_out  <= w_match;
        end else begin
            r_out  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_hit && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out         = r_out;
    assign match_count = r_count;
    assign cur_len     = r_len;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param against a bit-queue
//               reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               Sin;
    logic               en;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   cur_len;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the bits received since the last restart point.
    bit           m_q[$];
    logic [7:0]   m_pat;
    int           m_len;
    bit           m_ovl;
    int           m_out;
    int           m_cnt;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Sin         (Sin),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .match_count (match_count),
        .cur_len     (cur_len)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit tail_matches();
        int n = m_q.size();
        if (m_len == 0 || n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (m_q[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_pat = 8'b1001; m_len = 4; m_ovl = 1'b1;
            m_q.delete(); m_out = 0; m_cnt = 0;
        end else if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_overlap;
            m_q.delete(); m_out = 0;
            if (cnt_clr) m_cnt = 0;
        end else begin
            m_out = 0;
            if (en) begin
                m_q.push_back(Sin);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                if (tail_matches()) begin
                    m_out = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) m_q.delete();
                end
            end
            if (cnt_clr) m_cnt = 0;
        end
    endtask

    task automatic step(input bit r, input bit ld, input bit e, input bit s, input bit clr);
        reset = r; cfg_load = ld; en = e; Sin = s; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_value("out", int'(out), m_out);
        check_value("count", int'(match_count), m_cnt);
        check_value("cur_len", int'(cur_len), m_len);
    endtask

    task automatic load_cfg(input logic [7:0] p, input int l, input bit o);
        cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit stream [14] = '{0,1,0,0,1,0,0,1,1,1,1,0,0,1};
        logic [13:0] pulses;
        int run;

        reset = 1'b1; cfg_load = 1'b0; en = 1'b0; Sin = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("rst_out", int'(out), 0);
        check_value("rst_count", int'(match_count), 0);
        check_value("rst_len", int'(cur_len), 4);

        // Default overlapping 1001
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b0, 1'b1, stream[k], 1'b0);
            pulses[k] = out;
        end
        check_value("dflt_pulses", int'(pulses), (1 << 4) | (1 << 7) | (1 << 13));
        check_value("dflt_cnt", int'(match_count), 3);

        // Same stream, non-overlapping
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b1001, 4, 1'b0);
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b0, 1'b1, stream[k], 1'b0);
            pulses[k] = out;
        end
        check_value("novl_pulses", int'(pulses), (1 << 4) | (1 << 13));
        check_value("novl_cnt", int'(match_count), 2);

        // "11" overlapping: three consecutive pulses
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b11, 2, 1'b1);
        run = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            run += int'(out);
            pulses[k] = out;
        end
        check_value("ovl11_pulses", int'(pulses[3:0]), 4'b1110);
        check_value("ovl11_cnt", int'(match_count), 3);

        // "11" non-overlapping: two pulses two cycles apart
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b11, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            pulses[k] = out;
        end
        check_value("novl11_pulses", int'(pulses[3:0]), 4'b1010);
        check_value("novl11_cnt", int'(match_count), 2);

        // en gaps inside 1001
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b1001, 4, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_value("gap_pre", int'(out), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_value("gap_out", int'(out), 1);
        check_value("gap_cnt", int'(match_count), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("gap_drop", int'(out), 0);

        // Length clamp
        load_cfg(8'hFF, 12, 1'b1);
        check_value("clamp_len", int'(cur_len), MAX_LEN);

        // Saturation and clear-vs-increment
        load_cfg(8'b11, 2, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_value("sat_cnt", int'(match_count), 3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_value("clr_out", int'(out), 1);
        check_value("clr_cnt", int'(match_count), 0);

        // Reset mid-pattern discards partial match
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_value("rst_mid_len", int'(cur_len), 4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_value("rst_mid_out", int'(out), 0);

        // Sin presented during cfg_load is discarded
        cfg_pattern = 8'b11; cfg_len = LEN_W'(2); cfg_overlap = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_value("ld_discard", int'(out), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_value("ld_second", int'(out), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, ld, e, s, c;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 9) != 0);
            s  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 49) == 0);
            if (ld) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15))
                                                          : LEN_W'($urandom_range(0, 4));
                cfg_overlap = 1'($urandom_range(0, 1));
            end
            step(r, ld, e, s, c);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector with a Moore-style registered output. It compares the incoming serial stream against a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping and non-overlapping matching are both supported, and a saturating match counter is included. The block supersedes the fixed "1001" overlapping detector: after reset its configuration reproduces that behaviour exactly, and it sits on the same serial-input path in front of the downstream event logic.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of match_count
- RST_PATTERN, 'b1001, pattern loaded at reset (LSB-aligned, MAX_LEN bits)
- RST_LEN, 4, pattern length loaded at reset
- RST_OVERLAP, 1, overlap mode loaded at reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- Sin  in  1  serial data bit
- en  in  1  Sin is sampled only when en=1
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len, cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; the first bit received matches cfg_pattern[len-1], the last matches bit 0
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_count
- out  out  1  high for the cycle following a completed match
- match_count  out  CNT_W  number of matches, saturating
- cur_len  out  $clog2(MAX_LEN+1)  active (clamped) pattern length

## Operation
- Internal state:
  - config registers pat, len, ovl
  - history shift register hist[MAX_LEN-1:0]
  - fill counter, 0..len, saturating at len
- Reset:
  - pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP
  - hist=0, fill=0
  - out=0, match_count=0, cur_len=RST_LEN
- cfg_load=1:
  - latch the config
  - cfg_len > MAX_LEN is clamped to MAX_LEN
  - hist and fill are cleared, out drops to 0 next cycle, match_count is kept
  - the Sin bit presented that cycle is discarded, even if en=1
- len=0: detection disabled; out stays 0 and the counter does not change.
- Sampling (en=1, no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], Sin}
  - fill_n = min(fill+1, len)
- Match condition: fill_n == len AND hist_n[len-1:0] == pat[len-1:0].
- On match:
  - out <= 1
  - match_count increments, saturating at 2^CNT_W-1
  - ovl=1: fill keeps fill_n, so trailing bits may begin the next match
  - ovl=0: fill <= 0, so the next match needs len fresh bits
- en=0: hist and fill hold, and out <= 0.
- Priority:
  - reset > cfg_load > sampling
  - cnt_clr beats a simultaneous increment (count becomes 0)

## Timing
- Latency: out is high in the cycle after the rising edge that samples the final pattern bit.
- out is registered, so it never depends combinationally on Sin.
- out lasts one cycle per match. Back-to-back matches give consecutive high cycles, e.g. pattern "11" with ovl=1 and input 1,1,1.
- match_count updates on the same edge that sets out.
- cur_len reflects a new configuration one cycle after cfg_load.
- Reset asserted mid-pattern: any partial match is discarded and the configuration returns to the RST_* values on that edge.

## Test plan
- Default config (1001, overlap), en=1, Sin = 0,1,0,0,1,0,0,1,1,1,1,0,0,1, one bit per cycle -> out pulses after the 5th, 8th and 14th bits; match_count=3.
- Same stream after cfg_load with pattern=1001, len=4, overlap=0 -> out pulses after the 5th and 14th bits only; match_count=2.
- cfg_load pattern=11, len=2, overlap=1; Sin=1,1,1,1 -> out high for 3 consecutive cycles; count=3. With overlap=0 the same input gives 2 pulses, 2 cycles apart.
- en low for 3 cycles between the bits 1,0 | 0,1 of 1001 -> exactly one match, with out one cycle after the final sampled 1. cfg_len=12 with MAX_LEN=8 -> cur_len=8.
- CNT_W=2, six matches -> count saturates at 3. cnt_clr asserted together with a match -> count 0 while out still pulses.
- Reset asserted after 1,0,0, then released and a single 1 applied -> no match. cfg_load with en=1 and Sin=1 in the same cycle -> that bit is ignored and fill=0.
